// File: rtl/riscv_constants.sv
// Shared RISC-V pipeline constants: writeback select, LSU state encoding,
// load/store size codes and small helpers for byte-lane handling.
package riscv_constants;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Request payload held stable on the memory port while mem_req is high.
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } lsu_mem_req_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (size)
            2'b00:   be = BE_W'(4'b0001 << off);
            2'b01:   be = BE_W'(4'b0011 << off);
            default: be = {BE_W{1'b1}};
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load extraction: picks the addressed byte/halfword out of
// the read word and sign- or zero-extends it to a full word.
module riscv_load_align
    import riscv_constants::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] word
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        word    = shifted;
        case (funct3)
            F3_B:    word = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   word = {24'b0, shifted[7:0]};
            F3_H:    word = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   word = {16'b0, shifted[15:0]};
            default: word = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding access, word-aligned memory port with
// byte enables, misalignment abort and registered load result.
module riscv_lsu
    import riscv_constants::*;
#(
    parameter int unsigned WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [2:0]             funct3,
    input  logic [WORD_LENGTH-1:0] addr,
    input  logic [WORD_LENGTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] load_data,
    output logic                   misaligned,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [WORD_LENGTH-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [WORD_LENGTH-1:0] mem_wdata,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [WORD_LENGTH-1:0] mem_rdata
);

    lsu_state_e             state_q, state_d;
    lsu_mem_req_t           req_q, req_d;
    logic [1:0]             offset_q, offset_d;
    logic [2:0]             funct3_q, funct3_d;
    logic                   misaligned_q, misaligned_d;
    logic [WORD_LENGTH-1:0] load_data_q, load_data_d;
    logic [XLEN-1:0]        align_word;
    logic                   abort_c;

    riscv_load_align u_align (
        .rdata  (mem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .word   (align_word)
    );

    assign abort_c = !f3_legal(funct3) || size_misaligned(funct3[1:0], addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            req_q        <= '0;
            offset_q     <= 2'b00;
            funct3_q     <= 3'b000;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            offset_q     <= offset_d;
            funct3_q     <= funct3_d;
            misaligned_q <= misaligned_d;
            load_data_q  <= load_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        offset_d     = offset_q;
        funct3_d     = funct3_q;
        misaligned_d = misaligned_q;
        load_data_d  = load_data_q;

        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    if (abort_c) begin
                        misaligned_d = 1'b1;
                        state_d      = LSU_DONE;
                    end else begin
                        req_d.we    = is_store;
                        req_d.addr  = {addr[WORD_LENGTH-1:2], 2'b00};
                        req_d.be    = byte_en(funct3[1:0], addr[1:0]);
                        req_d.wdata = store_lanes(funct3[1:0], wdata);
                        offset_d    = addr[1:0];
                        funct3_d    = funct3;
                        state_d     = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (mem_gnt) begin
                    state_d = req_q.we ? LSU_DONE : LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid) begin
                    load_data_d = align_word;
                    state_d     = LSU_DONE;
                end
            end
            LSU_DONE: begin
                misaligned_d = 1'b0;
                state_d      = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // busy rises combinationally with start so the pipeline stalls in the same cycle
    assign busy       = (state_q != LSU_IDLE) || start;
    assign done       = (state_q == LSU_DONE);
    assign misaligned = misaligned_q;
    assign load_data  = load_data_q;
    assign mem_req    = (state_q == LSU_REQ);
    assign mem_we     = (state_q == LSU_REQ) && req_q.we;
    assign mem_addr   = req_q.addr;
    assign mem_be     = req_q.be;
    assign mem_wdata  = req_q.wdata;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: access-level model predicting port activity per cycle,
// directed accesses with literal spot checks, reset-in-WAIT scenario.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, misaligned;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    riscv_lsu #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .load_data(load_data),
        .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the current access, in absolute cycle numbers
    bit          model_on = 1'b0;
    int          m_t = -10, m_req_lo = 1, m_req_hi = 0, m_done = -10;
    logic        m_st = 1'b0, m_mis = 1'b0;
    logic [31:0] m_addr = '0, m_wd = '0, m_ld_old = '0, m_ld_new = '0;
    logic [3:0]  m_be = '0;

    // Observations collected per access
    int          req_cnt, done_cnt, last_done_cyc;
    logic        last_mis;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic int f3_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_abort(input logic [2:0] f3, input logic [1:0] off);
        int sz = f3_size(f3);
        return (sz == 0) || ((int'(off) % sz) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
        int sz = f3_size(f3);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(off) && i < int'(off) + sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [2:0] f3, input logic [31:0] wd);
        int sz = f3_size(f3);
        logic [31:0] r = wd;
        if (sz != 0)
            for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * int'(off));
        if (f3_size(f3) == 1) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (f3_size(f3) == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Per-cycle compare against the model, plus observation capture
    always @(negedge clk) begin : compare
        logic exp_req, exp_done, exp_busy;
        if (mem_req) begin
            req_cnt++;
            last_addr  = mem_addr;
            last_be    = mem_be;
            last_wdata = mem_wdata;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_mis      = misaligned;
        end
        if (model_on && !rst) begin
            exp_req  = (cyc >= m_req_lo) && (cyc <= m_req_hi);
            exp_done = (cyc == m_done);
            exp_busy = (cyc >= m_t) && (cyc <= m_done);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            chk("mem_we", 32'(mem_we), 32'(exp_req && m_st));
            chk("done", 32'(done), 32'(exp_done));
            chk("misaligned", 32'(misaligned), 32'(exp_done && m_mis));
            chk("load_data", load_data, (cyc >= m_done) ? m_ld_new : m_ld_old);
            if (exp_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_be", 32'(mem_be), 32'(m_be));
                if (m_st) chk("mem_wdata", mem_wdata, m_wd);
            end
        end
    end

    task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int gd, input int rdl, input bit extra);
        int   t;
        logic ab;
        @(posedge clk); #1;
        t  = cyc;
        ab = model_abort(f3, a[1:0]);
        m_ld_old = m_ld_new;
        m_t      = t;
        m_st     = st;
        m_mis    = ab;
        m_addr   = {a[31:2], 2'b00};
        m_be     = model_be(f3, a[1:0]);
        m_wd     = model_lanes(f3, wd);
        if (ab) begin
            m_req_lo = 1; m_req_hi = 0; m_done = t + 1;
        end else begin
            m_req_lo = t + 1;
            m_req_hi = t + 1 + gd;
            m_done   = st ? t + 2 + gd : t + 3 + gd + rdl;
            if (!st) m_ld_new = model_load(f3, a[1:0], rd);
        end
        req_cnt = 0; done_cnt = 0; last_mis = 1'b0;
        for (int c = t; c <= m_done; c++) begin
            start    = (c == t) || (extra && c == t + 1);
            is_store = (c == t) ? st : ~st;
            funct3   = f3;
            addr     = (c == t) ? a : ~a;
            wdata    = (c == t) ? wd : ~wd;
            mem_gnt  = !ab && (c == t + 1 + gd);
            mem_rvalid = !st && !ab && (c == t + 2 + gd + rdl);
            if (gd > 0 && c == t + 1) mem_rvalid = 1'b1;
            mem_rdata = (!st && !ab && c == t + 2 + gd + rdl) ? rd : 32'hA5A5_5A5A;
            @(posedge clk); #1;
        end
        start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst load_data", load_data, 32'd0);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_be", 32'(mem_be), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_on = 1'b1;

        // LW, immediate gnt/rvalid
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        chk("lw addr", last_addr, 32'h100);
        chk("lw be", 32'(last_be), 32'h0000_000F);
        chk("lw latency", 32'(last_done_cyc - m_t), 32'd3);
        chk("lw data", load_data, 32'hDEAD_BEEF);

        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
        chk("lb be", 32'(last_be), 32'h0000_0008);
        chk("lb data", load_data, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
        chk("lbu data", load_data, 32'h0000_0080);

        // SH with gnt arriving on the third request cycle
        do_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 2, 0, 1'b0);
        chk("sh req cycles", 32'(req_cnt), 32'd3);
        chk("sh be", 32'(last_be), 32'h0000_000C);
        chk("sh wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh keeps load_data", load_data, 32'h0000_0080);

        // LW misaligned abort
        do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
        chk("lw mis req cycles", 32'(req_cnt), 32'd0);
        chk("lw mis flag", 32'(last_mis), 32'd1);
        chk("lw mis latency", 32'(last_done_cyc - m_t), 32'd1);
        chk("lw mis keeps load_data", load_data, 32'h0000_0080);

        do_access(1'b1, 3'b000, 32'h001, 32'h0000_005A, 32'h0, 0, 0, 1'b1);
        chk("sb wdata", last_wdata, 32'h5A5A_5A5A);
        chk("sb latency", 32'(last_done_cyc - m_t), 32'd2);
        do_access(1'b0, 3'b001, 32'h002, 32'h0, 32'h8001_0000, 0, 2, 1'b0);
        chk("lh data", load_data, 32'hFFFF_8001);
        do_access(1'b0, 3'b101, 32'h106, 32'h0, 32'h9ABC_0000, 1, 1, 1'b1);
        chk("lhu data", load_data, 32'h0000_9ABC);
        do_access(1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 0, 1'b1);
        do_access(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0, 1'b0);
        chk("illegal f3 flag", 32'(last_mis), 32'd1);
        do_access(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 1, 0, 1'b1);
        do_access(1'b1, 3'b010, 32'h302, 32'h1111_2222, 32'h0, 0, 0, 1'b0);
        do_access(1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 0, 0, 1'b0);
        chk("lb pos data", load_data, 32'h0000_007F);

        // Reset while waiting for read data, then a stray response
        model_on = 1'b0;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1;
        start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk("rstw mem_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstw busy in wait", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstw busy", 32'(busy), 32'd0);
        chk("rstw mem_req", 32'(mem_req), 32'd0);
        chk("rstw mem_be", 32'(mem_be), 32'd0);
        chk("rstw load_data", load_data, 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw busy after", 32'(busy), 32'd0);
        chk("rstw load_data after", load_data, 32'd0);
        chk("rstw no done", 32'(done_cnt), 32'd0);
        m_ld_new = 32'd0;
        model_on = 1'b1;

        do_access(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b0);
        chk("recovery data", load_data, 32'h0BAD_F00D);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 Parameter WORD_LENGTH, default 32, data/address width in bits; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  pipeline requests a memory access this cycle.
REQ-005 is_store  input  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; sampled with start.
REQ-007 addr  input  WORD_LENGTH  byte address; sampled with start.
REQ-008 wdata  input  WORD_LENGTH  store data, right-aligned; sampled with start.
REQ-009 busy  output  1  access in progress; pipeline must stall.
REQ-010 done  output  1  one-cycle pulse: access complete.
REQ-011 load_data  output  WORD_LENGTH  aligned, extended load result; feeds writeback data input.
REQ-012 misaligned  output  1  valid with done: access aborted, no memory traffic.
REQ-013 mem_req  output  1  memory request valid.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  WORD_LENGTH  word-aligned address (bits 1:0 = 0).
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_wdata  output  WORD_LENGTH  store data replicated into byte lanes.
REQ-018 mem_gnt  input  1  memory accepts request this cycle.
REQ-019 mem_rvalid  input  1  read data valid.
REQ-020 mem_rdata  input  WORD_LENGTH  read word.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE; busy = (state != IDLE) or (start in IDLE).
REQ-022 IDLE: start with legal alignment -> latch request, go REQ; start misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal funct3 -> go DONE with misaligned=1.
REQ-023 REQ: mem_req=1, request fields held stable until mem_gnt; on gnt, store -> DONE, load -> WAIT.
REQ-024 WAIT: on mem_rvalid, register extracted load_data, go DONE; mem_rvalid outside WAIT is ignored.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-026 start outside IDLE is ignored; inputs not re-sampled until IDLE.
REQ-027 Minimum latency with gnt/rvalid immediate: store done 2 cycles after start, load 3 cycles.
REQ-028 mem_be: B -> 1 << addr[1:0]; H -> 0011 << addr[1:0]; W -> 1111; mem_we=1 only for stores.
REQ-029 mem_wdata: B replicates wdata[7:0] x4; H replicates wdata[15:0] x2; W passes wdata.
REQ-030 Load extraction: select byte/halfword by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-031 load_data holds last value until next completed load; stores and misaligned aborts leave it unchanged.
REQ-032 misaligned is 0 except during the DONE cycle of an aborted access.

Reset
REQ-033 rst forces state IDLE in the same edge, including mid-REQ or mid-WAIT; an outstanding response is discarded.
REQ-034 Reset values: busy 0, done 0, misaligned 0, load_data 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0.

Structure
REQ-035 LSU state enum and funct3 size/sign constants shall live in the shared riscv_constants package beside WB_SEL.
REQ-036 Load extraction/extension shall be sub-module riscv_load_align (combinational: rdata, offset, funct3 -> word).

Verification
REQ-037 LW addr 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, done on cycle 3, load_data 0xDEADBEEF.
REQ-038 LB addr 0x103, rdata 0x80FFFFFF -> be 1000, load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles -> mem_req held 3 cycles, be 1100, mem_wdata 0xABCDABCD, done once.
REQ-040 LW addr 0x101 -> no mem_req, done with misaligned=1 the next cycle, load_data unchanged.
REQ-041 rst asserted in WAIT, then stray rvalid -> state IDLE, no done, load_data 0.
REQ-042 start pulsed during busy -> ignored; exactly one done per accepted access.
